game_status_ctrl: RTL and testbench
===================================

# game_status_ctrl

Game-state sequencer that sits directly upstream of the video game controller. It turns synchronized push-button inputs and the controller's `collison_detect` flag into the `game_info_reg` control byte and the `randomized_value` byte that the controller consumes. It also keeps the survival score and level, and issues a soft reset that clears the controller's sticky collision flag between games. It tracks frame boundaries from the shared pixel address.

## Interface
- `LEVEL_UP_SCORE`, default 16'd1800: score at or above which the fast-level bit is set (about 30 s at 60 frames/s).
- `RESTART_CYCLES`, default 3'd4: number of cycles `game_rst` stays asserted.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

- `clock` input 1: 25 MHz pixel clock.
- `rst` input 1: synchronous, active-high reset.
- `btn_left` input 1: raw left button, asynchronous, debounced externally.
- `btn_right` input 1: raw right button.
- `btn_start` input 1: raw start/restart button.
- `btn_icon` input 1: raw icon-select button.
- `collison_detect` input 1: collision flag from the video game controller; sticky until that block is reset.
- `Pixel_row` input 10: current pixel row.
- `Pixel_column` input 10: current pixel column.
- `game_info_reg` output 8: control byte for the controller.
- `randomized_value` output 8: LFSR low byte.
- `score` output 16: frames survived, saturating.
- `game_rst` output 1: soft reset pulse to the video game controller.

## Operation
- **Button conditioning:** each button passes through a 2-flop synchronizer. `btn_start` and `btn_icon` additionally get a rising-edge detector that produces a one-cycle pulse.
- **Frame tick:** one-cycle pulse on the first cycle where `Pixel_row==0 && Pixel_column==0`. It does not repeat while that address is held.
- **LFSR:** 16-bit Galois, mask 16'hB400, shifts every cycle in every state, never reaches 0. `randomized_value = lfsr[7:0]`.
- **`game_info_reg` bit map**, decoded from registered state:
  - [1:0] move: 2'b10 = left only pressed, 2'b01 = right only pressed, 2'b00 otherwise (including both pressed). Forced 2'b00 outside PLAY.
  - [2] reserved, always 0.
  - [3] playing: 1 in PLAY.
  - [4] fast level: 1 when `score >= LEVEL_UP_SCORE`.
  - [6:5] icon select.
  - [7] game completed: 1 in OVER.
- **Icon select:** each `btn_icon` pulse in IDLE increments it modulo 4. Pulses in other states are ignored; the value holds across games.
- **States:**
  - IDLE: start pulse → PLAY. Collision is ignored.
  - PLAY: each frame tick increments `score`, saturating at 16'hFFFF. `collison_detect==1` → OVER. A start pulse is ignored.
  - OVER: `score` is frozen. Start pulse → RESTART.
  - RESTART: `game_rst=1` for `RESTART_CYCLES` cycles. `score` clears on entry. Then → IDLE. Start pulses are ignored.
- **Simultaneous events:**
  - Collision and frame tick in the same PLAY cycle: → OVER, no increment.
  - `rst` in any state: overrides everything; the state machine returns to IDLE.

## Timing
- **Reset values:** `game_info_reg`=8'h00, `randomized_value`=8'hE1, `score`=0, `game_rst`=0, state IDLE, icon select 2'b00.
- **Button latency:** a raw button change at cycle n reaches the synchronizer output at n+2. The edge pulse or state update registers at n+3, so `game_info_reg` reflects it at n+3.
- **Collision latency:** `collison_detect` sampled high at cycle n in PLAY gives state OVER and `game_info_reg[7]=1` at n+1.
- **Score timing:** `score` updates the cycle after the frame tick. Bit [4] follows combinationally from `score`.
- **Soft reset:** `game_rst` is registered. It goes high the cycle after the start pulse in OVER and stays high exactly `RESTART_CYCLES` cycles. IDLE is entered the cycle `game_rst` falls.

## Test plan
- **Reset:** assert `rst` 2 cycles → `game_info_reg`=8'h00, `score`=0, `randomized_value`=8'hE1. Then free-run 65535 cycles → LFSR returns to 16'hACE1 and is never 0.
- **Start and move:**
  - Raise `btn_start` at cycle n → `game_info_reg[3]=1` at n+3.
  - Hold `btn_left` → [1:0]=2'b10.
  - Hold both buttons → [1:0]=2'b00.
- **Scoring:** in PLAY, drive 1800 frame ticks (pixel (0,0) once per frame) → `score`=1800 and [4]=1. Hold pixel (0,0) 5 cycles → one increment only.
- **Collision:**
  - Collision and frame tick in the same cycle at `score`=10 → next cycle [7]=1, state OVER, `score` stays 10.
  - Start pulse → `game_rst` high exactly 4 cycles, then IDLE with `score`=0.
- **Icon select:**
  - 5 `btn_icon` pulses in IDLE → [6:5]=2'b01.
  - Pulses in PLAY → unchanged.
- **Reset mid-RESTART:** assert `rst` during the 2nd `game_rst` cycle → `game_rst`=0 next cycle, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/game_status_ctrl.sv
// Game-state sequencer for the video game controller: button conditioning,
// frame-tick scoring, LFSR randomness and the between-game soft reset.
module game_status_ctrl #(
  parameter logic [15:0] LEVEL_UP_SCORE = 16'd1800,
  parameter logic [2:0]  RESTART_CYCLES = 3'd4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  input  logic        btn_icon,
  input  logic        collison_detect,
  input  logic [9:0]  Pixel_row,
  input  logic [9:0]  Pixel_column,
  output logic [7:0]  game_info_reg,
  output logic [7:0]  randomized_value,
  output logic [15:0] score,
  output logic        game_rst
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER, RESTART} state_t;

  state_t      state;
  logic [3:0]  sync1, sync2;   // {icon, start, right, left}
  logic        start_q, icon_q, origin_q;
  logic        start_pulse, icon_pulse, frame_tick, at_origin, playing;
  logic [15:0] lfsr;
  logic [2:0]  rcnt;
  logic [1:0]  icon_sel, move;

  assign at_origin   = (Pixel_row == 10'd0) && (Pixel_column == 10'd0);
  assign frame_tick  = at_origin & ~origin_q;
  assign start_pulse = sync2[2] & ~start_q;
  assign icon_pulse  = sync2[3] & ~icon_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      start_q  <= 1'b0;
      icon_q   <= 1'b0;
      origin_q <= 1'b0;
      lfsr     <= LFSR_SEED;
    end else begin
      sync1    <= {btn_icon, btn_start, btn_right, btn_left};
      sync2    <= sync1;
      start_q  <= sync2[2];
      icon_q   <= sync2[3];
      origin_q <= at_origin;
      // Galois right-shift; a non-zero seed keeps the sequence off zero
      lfsr     <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      score    <= '0;
      game_rst <= 1'b0;
      rcnt     <= '0;
      icon_sel <= '0;
      move     <= '0;
    end else begin
      move <= (sync2[0] & ~sync2[1]) ? 2'b10 :
              (sync2[1] & ~sync2[0]) ? 2'b01 : 2'b00;
      case (state)
        IDLE: begin
          if (icon_pulse)  icon_sel <= icon_sel + 2'd1;
          if (start_pulse) state    <= PLAY;
        end
        PLAY: begin
          // collision wins over a same-cycle frame tick
          if (collison_detect)
            state <= OVER;
          else if (frame_tick && score != 16'hFFFF)
            score <= score + 16'd1;
        end
        OVER: begin
          if (start_pulse) begin
            state    <= RESTART;
            game_rst <= 1'b1;
            score    <= '0;
            rcnt     <= '0;
          end
        end
        RESTART: begin
          if (rcnt == RESTART_CYCLES - 3'd1) begin
            state    <= IDLE;
            game_rst <= 1'b0;
          end else begin
            rcnt <= rcnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign playing          = (state == PLAY);
  assign randomized_value = lfsr[7:0];
  assign game_info_reg    = {state == OVER, icon_sel, score >= LEVEL_UP_SCORE,
                             playing, 1'b0, playing ? move : 2'b00};

endmodule

// File: tb/tb_game_status_ctrl.sv
// Randomized and directed bench for game_status_ctrl against a rule-level model.
module tb_game_status_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        btn_left = 0, btn_right = 0, btn_start = 0, btn_icon = 0;
  logic        collison_detect = 0;
  logic [9:0]  Pixel_row = 10'd1, Pixel_column = 10'd5;
  logic [7:0]  game_info_reg, randomized_value;
  logic [15:0] score;
  logic        game_rst;

  int errors = 0;
  int checks = 0;

  game_status_ctrl dut (
    .clock(clock), .rst(rst),
    .btn_left(btn_left), .btn_right(btn_right),
    .btn_start(btn_start), .btn_icon(btn_icon),
    .collison_detect(collison_detect),
    .Pixel_row(Pixel_row), .Pixel_column(Pixel_column),
    .game_info_reg(game_info_reg), .randomized_value(randomized_value),
    .score(score), .game_rst(game_rst)
  );

  always #20 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model: game rules at frame/button-event level ----
  localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2, M_RESTART = 3;
  int          m_state, m_score, m_icon, m_left;
  logic [1:0]  m_mv;
  logic [15:0] m_lfsr;
  logic        m_org_prev;
  logic [3:0]  dl [1:3];   // raw buttons seen 1, 2, 3 edges ago {icon,start,right,left}

  task automatic model_reset();
    m_state = M_IDLE; m_score = 0; m_icon = 0; m_left = 0; m_mv = 2'b00;
    m_lfsr = 16'hACE1; m_org_prev = 0;
    for (int i = 1; i <= 3; i++) dl[i] = 4'b0;
  endtask

  task automatic model_step();
    logic sp, ip, tick, org;
    if (rst) begin
      model_reset();
      return;
    end
    sp   = dl[2][2] & ~dl[3][2];
    ip   = dl[2][3] & ~dl[3][3];
    org  = (Pixel_row == 0) && (Pixel_column == 0);
    tick = org & ~m_org_prev;
    case (m_state)
      M_IDLE: begin
        if (ip) m_icon = (m_icon + 1) % 4;
        if (sp) m_state = M_PLAY;
      end
      M_PLAY: begin
        if (collison_detect) m_state = M_OVER;
        else if (tick && m_score < 65535) m_score++;
      end
      M_OVER: if (sp) begin m_state = M_RESTART; m_score = 0; m_left = 4; end
      default: begin
        m_left--;
        if (m_left == 0) m_state = M_IDLE;
      end
    endcase
    m_mv = (dl[2][0] && !dl[2][1]) ? 2'b10 : (dl[2][1] && !dl[2][0]) ? 2'b01 : 2'b00;
    dl[3] = dl[2]; dl[2] = dl[1];
    dl[1] = {btn_icon, btn_start, btn_right, btn_left};
    m_org_prev = org;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  function automatic logic [7:0] exp_gir();
    logic pl;
    pl = (m_state == M_PLAY);
    return {m_state == M_OVER, 2'(m_icon), m_score >= 1800, pl, 1'b0, pl ? m_mv : 2'b00};
  endfunction

  // one clock: advance model at the edge, compare just after it
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    chk("gir", game_info_reg, exp_gir());
    chk("rand", randomized_value, m_lfsr[7:0]);
    chk("score", score, m_score);
    chk("game_rst", game_rst, m_state == M_RESTART);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_start();
    btn_start = 1; run(4); btn_start = 0; run(4);
  endtask

  task automatic press_icon();
    btn_icon = 1; run(4); btn_icon = 0; run(4);
  endtask

  task automatic frame();
    Pixel_row = 0; Pixel_column = 0; cycle();
    Pixel_row = 1; Pixel_column = 5; cycle();
  endtask

  task automatic start_and_count(input string tag);
    int cnt;
    cnt = 0;
    btn_start = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 3) btn_start = 0;
      if (game_rst) cnt++;
    end
    chk(tag, cnt, 4);
    chk({tag, "_idle"}, game_info_reg[7] | game_info_reg[3], 0);
    chk({tag, "_score0"}, score, 0);
  endtask

  initial begin
    model_reset();
    run(2);
    chk("rst_gir", game_info_reg, 8'h00);
    chk("rst_score", score, 0);
    chk("rst_rand", randomized_value, 8'hE1);
    chk("rst_grst", game_rst, 0);
    rst = 0;

    // full LFSR period, every step compared with the model
    run(65535);
    chk("lfsr_period", randomized_value, 8'hE1);
    chk("lfsr_period_model", m_lfsr, 16'hACE1);

    for (int i = 0; i < 5; i++) press_icon();
    chk("icon5", game_info_reg[6:5], 2'b01);

    // start latency: visible exactly on the third edge
    btn_start = 1;
    cycle(); chk("start_n1", game_info_reg[3], 0);
    cycle(); chk("start_n2", game_info_reg[3], 0);
    cycle(); chk("start_n3", game_info_reg[3], 1);
    btn_start = 0; run(3);

    press_icon(); press_icon();
    chk("icon_play", game_info_reg[6:5], 2'b01);

    btn_left = 1; run(4);
    chk("move_left", game_info_reg[1:0], 2'b10);
    btn_right = 1; run(4);
    chk("move_both", game_info_reg[1:0], 2'b00);
    btn_left = 0; run(4);
    chk("move_right", game_info_reg[1:0], 2'b01);
    btn_right = 0; run(4);

    for (int i = 0; i < 1799; i++) frame();
    chk("score1799_fast", game_info_reg[4], 0);
    frame();
    chk("score1800", score, 1800);
    chk("fast", game_info_reg[4], 1);
    Pixel_row = 0; Pixel_column = 0; run(5);
    Pixel_row = 1; Pixel_column = 5; run(1);
    chk("origin_hold", score, 1801);

    collison_detect = 1; cycle(); collison_detect = 0;
    chk("over", game_info_reg[7], 1);
    chk("over_play", game_info_reg[3], 0);
    run(3);
    start_and_count("restart1");

    press_start();
    for (int i = 0; i < 10; i++) frame();
    chk("score10", score, 10);
    collison_detect = 1; Pixel_row = 0; Pixel_column = 0; cycle();
    collison_detect = 0; Pixel_row = 1; Pixel_column = 5;
    chk("coll_tick_over", game_info_reg[7], 1);
    chk("coll_tick_score", score, 10);
    run(3);
    chk("over_frozen", score, 10);
    start_and_count("restart2");

    // reset during the second game_rst cycle
    press_start();
    collison_detect = 1; cycle(); collison_detect = 0; run(2);
    btn_start = 1;
    begin
      int n;
      n = 0;
      while (!game_rst && n < 10) begin cycle(); n++; end
      chk("grst_seen", game_rst, 1);
    end
    btn_start = 0;
    cycle();
    chk("grst_2nd", game_rst, 1);
    rst = 1; cycle(); rst = 0;
    chk("midrst_grst", game_rst, 0);
    chk("midrst_gir", game_info_reg, 8'h00);
    chk("midrst_score", score, 0);
    chk("midrst_rand", randomized_value, 8'hE1);

    // randomized play against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_left  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) btn_right = 1'($urandom);
      if ($urandom_range(0, 9) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 11) == 0) btn_icon = ~btn_icon;
      collison_detect = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) begin Pixel_row = 0; Pixel_column = 0; end
      else begin Pixel_row = 10'($urandom_range(0, 3)); Pixel_column = 10'($urandom_range(1, 3)); end
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
